// File: rtl/donut_pkg.sv
// Shared definitions for the donut shading path: fixed-point format defaults
// (common to the squarer and the square-root block) and the isqrt FSM states.
package donut_pkg;

    // Operand width and fractional bits; DEF_FRAC matches the squarer's POST_SHIFT.
    localparam int DEF_N    = 16;
    localparam int DEF_FRAC = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } isqrt_state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: bring down the next radicand bit pair,
// try subtracting (root<<2)|1, and shift the resulting root bit in.
module isqrt_step #(
    parameter int ITER = 12
) (
    input  logic [ITER+1:0] rem,
    input  logic [ITER-1:0] root,
    input  logic [1:0]      pair,
    output logic [ITER+1:0] rem_next,
    output logic [ITER-1:0] root_next
);

    logic [ITER+1:0] rem_sh;
    logic [ITER+1:0] trial;
    logic            ge;

    // Trial subtraction; the top bits lost by the shifts are provably zero
    // because the remainder never exceeds 2*root.
    always_comb begin
        rem_sh    = (rem << 2) | {{ITER{1'b0}}, pair};
        trial     = {root, 2'b01};
        ge        = (rem_sh >= trial);
        rem_next  = ge ? (rem_sh - trial) : rem_sh;
        root_next = (root << 1) | {{(ITER-1){1'b0}}, ge};
    end

endmodule

// File: rtl/isqrt.sv
// Sequential fixed-point square root: floor(sqrt(x * 2^FRAC)) for a signed
// Q(N-FRAC).FRAC operand, one result bit per cycle, one operation in flight.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. in_ready is high only in IDLE, out_valid only in DONE, so they are never
// high together. Outputs hold steady in DONE until out_ready is seen.
// N + FRAC must be even so the radicand splits into whole bit pairs.
module isqrt
    import donut_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int FRAC = DEF_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_exact,
    output logic         out_neg
);

    localparam int RAD_W = N + FRAC;
    localparam int ITER  = RAD_W / 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    isqrt_state_t     state, state_next;
    logic [RAD_W-1:0] rad;
    logic [ITER+1:0]  rem, rem_next;
    logic [ITER-1:0]  root, root_next;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    isqrt_step #(.ITER(ITER)) u_step (
        .rem       (rem),
        .root      (root),
        .pair      (rad[RAD_W-1:RAD_W-2]),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load the pre-shifted radicand on accept, then iterate.
    // Negative operands run all iterations too so latency stays uniform.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rad  <= {in_data, {FRAC{1'b0}}};
                        rem  <= '0;
                        root <= '0;
                        cnt  <= CNT_W'(ITER - 1);
                        neg  <= in_data[N-1];
                    end
                end
                BUSY: begin
                    rad  <= rad << 2;
                    rem  <= rem_next;
                    root <= root_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result presentation: only driven in DONE, masked for negative operands.
    always_comb begin
        out_data  = '0;
        out_exact = 1'b0;
        out_neg   = 1'b0;
        if (state == DONE) begin
            out_neg = neg;
            if (!neg) begin
                out_data  = N'(root);
                out_exact = (rem == '0);
            end
        end
    end

endmodule

// File: tb/tb_isqrt.sv
// Bench for isqrt: directed spec values, backpressure, mid-operation reset,
// back-to-back spacing and random operands against a binary-search model.
module tb_isqrt;

    localparam int N    = 16;
    localparam int ITER = 12;
    localparam int OW   = N + 2;   // {neg, exact, data}

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_exact;
    logic         out_neg;

    int checks   = 0;
    int failures = 0;
    logic [OW-1:0] exp_q[$];

    isqrt #(.N(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exact (out_exact),
        .out_neg   (out_neg)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference: floor(sqrt(x*256)) by binary search, negative operands masked.
    function automatic logic [OW-1:0] ref_model(input logic [N-1:0] x);
        longint v, lo, hi, mid;
        logic   ex;
        if (x[N-1]) return {1'b1, 1'b0, {N{1'b0}}};
        v  = longint'(x) * 256;
        lo = 0;
        hi = 4096;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= v) lo = mid;
            else                hi = mid;
        end
        ex = (lo * lo == v);
        return {1'b0, ex, lo[N-1:0]};
    endfunction

    // Driver: wait for in_ready, present one operand for one accept edge.
    task automatic drive_op(input logic [N-1:0] x, output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        in_valid = 1'b1;
        in_data  = x;
        exp_q.push_back(ref_model(x));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Receiver: measure cycles from accept to out_valid, stall, then take it.
    task automatic get_result(input int stall, output logic [OW-1:0] got,
                              output int lat, output bit timeout);
        lat = 0;
        timeout = 1'b0;
        got = '0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            timeout = 1'b1;
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        got = {out_neg, out_exact, out_data};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if ({out_neg, out_exact, out_data} !== {OW{1'b0}}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {out_neg, out_exact, out_data});
        end
    endtask

    task automatic test_directed();
        logic [N-1:0]  xs   [7];
        logic [OW-1:0] want [7];
        logic [OW-1:0] got, exp;
        int lat;
        bit to_in, to_out;
        xs   = '{16'h0100, 16'h0400, 16'h0200, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        want = '{{1'b0, 1'b1, 16'h0100}, {1'b0, 1'b1, 16'h0200}, {1'b0, 1'b0, 16'h016A},
                 {1'b0, 1'b1, 16'h0000}, {1'b0, 1'b0, 16'h0B50}, {1'b1, 1'b0, 16'h0000},
                 {1'b1, 1'b0, 16'h0000}};
        for (int i = 0; i < 7; i++) begin
            drive_op(xs[i], to_in);
            get_result(0, got, lat, to_out);
            checks++;
            if (to_in || to_out) begin
                failures++;
                $display("FAIL directed_timeout x=%h in=%b out=%b", xs[i], to_in, to_out);
                exp_q.delete();
                continue;
            end
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL directed_model x=%h got=%h exp=%h", xs[i], got, exp);
            end
            checks++;
            if (got !== want[i]) begin
                failures++;
                $display("FAIL directed_const x=%h got=%h exp=%h", xs[i], got, want[i]);
            end
            checks++;
            if (lat != ITER) begin
                failures++;
                $display("FAIL directed_latency x=%h got=%0d exp=%0d", xs[i], lat, ITER);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] held, got, exp;
        int n, lat;
        bit to_in, to_out;
        drive_op(16'h0900, to_in);
        in_valid = 1'b1;
        in_data  = 16'h0100;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (to_in || !out_valid) begin
            failures++;
            $display("FAIL bp_timeout in=%b out_valid=%b", to_in, out_valid);
            in_valid = 1'b0;
            exp_q.delete();
            return;
        end
        held = {out_neg, out_exact, out_data};
        exp  = exp_q.pop_front();
        checks++;
        if (held !== exp) begin
            failures++;
            $display("FAIL bp_result got=%h exp=%h", held, exp);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, out_neg, out_exact, out_data} !== {2'b10, held}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b_%b_%h exp=1_0_%h",
                         c, out_valid, in_ready, {out_neg, out_exact, out_data}, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL bp_after_handshake got=%b%b exp=10", in_ready, out_valid);
        end
        exp_q.push_back(ref_model(in_data));
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_result(0, got, lat, to_out);
        checks++;
        if (to_out) begin
            failures++;
            $display("FAIL bp_second_timeout got=none exp=result");
            exp_q.delete();
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || lat != ITER) begin
            failures++;
            $display("FAIL bp_second got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, ITER);
        end
    endtask

    task automatic test_reset_mid();
        bit to_in;
        int seen;
        drive_op(16'h0400, to_in);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_neg, out_exact, out_data} !== {2'b10, {OW{1'b0}}}) begin
            failures++;
            $display("FAIL rst_mid_immediate got=%b%b_%h exp=10_0", in_ready, out_valid,
                     {out_neg, out_exact, out_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1 || to_in) begin
            failures++;
            $display("FAIL rst_mid_discard got=%0d valid cycles in_ready=%b exp=0 valid, ready=1",
                     seen, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, accepts, outs, last_acc;
        logic [OW-1:0] got, exp;
        cyc = 0; accepts = 0; outs = 0; last_acc = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'($urandom_range(0, 16'h7FFF));
        while (outs < 4 && cyc < 200) begin
            if (out_valid) begin
                got = {out_neg, out_exact, out_data};
                exp = exp_q.pop_front();
                outs++;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL b2b_result got=%h exp=%h", got, exp);
                end
            end
            if (in_ready && in_valid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != ITER + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - last_acc, ITER + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
                exp_q.push_back(ref_model(in_data));
            end
            @(posedge clk); #1;
            cyc++;
            in_data = 16'($urandom_range(0, 16'h7FFF));
            if (accepts == 4) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (outs != 4) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=4", outs);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [N-1:0]  x;
        logic [OW-1:0] got, exp;
        int lat;
        bit to_in, to_out;
        for (int i = 0; i < 2000; i++) begin
            x = 16'($urandom_range(0, 16'h7FFF));
            drive_op(x, to_in);
            get_result(int'($urandom_range(0, 3)), got, lat, to_out);
            checks++;
            if (to_in || to_out) begin
                failures++;
                $display("FAIL random_timeout x=%h in=%b out=%b", x, to_in, to_out);
                exp_q.delete();
                break;
            end
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || lat != ITER) begin
                failures++;
                $display("FAIL random x=%h got=%h lat=%0d exp=%h lat=%0d", x, got, lat, exp, ITER);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
